// File: rtl/bus_sequencer_if.sv
// Bus-side signal bundle between the sequencer and the bus multiplexer.
interface bus_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             run;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] bus;
  logic [3:0]       sel;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] r0;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic [WIDTH-1:0] r3;
  logic [WIDTH-1:0] r4;
  logic [WIDTH-1:0] r5;
  logic [WIDTH-1:0] r6;
  logic [WIDTH-1:0] r7;
  logic [WIDTH-1:0] r;
  logic             done;

  // Sequencer side: takes run/din/bus, drives select, register exports, done.
  modport master (
    input  run, din, bus,
    output sel, imm, r0, r1, r2, r3, r4, r5, r6, r7, r, done
  );

  // Environment side: multiplexer plus instruction source.
  modport slave (
    output run, din, bus,
    input  sel, imm, r0, r1, r2, r3, r4, r5, r6, r7, r, done
  );
endinterface

// File: rtl/bus_sequencer.sv
// Multi-cycle instruction sequencer: decodes mv/mvi/add/sub/nop, steers the
// bus multiplexer through sel and captures the bus into R0..R7, A and G.
module bus_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  bus_sequencer_if.master bif
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [3:0] SEL_IMM  = 4'b1000;
  localparam logic [3:0] SEL_G    = 4'b1001;
  localparam logic [3:0] SEL_IDLE = 4'b1111;

  logic [1:0]       r_state;
  // Only opcode/rX/rY are kept; the low instruction bits are never decoded.
  logic [8:0]       r_ir;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_g;
  logic [WIDTH-1:0] r_imm;
  logic [WIDTH-1:0] r_regs [8];

  logic [2:0] w_op;
  logic [2:0] w_rx;
  logic [2:0] w_ry;
  logic [1:0] w_next;
  logic [3:0] w_sel;
  logic       w_done;
  logic       w_ir_ld;
  logic       w_imm_ld;
  logic       w_a_ld;
  logic       w_g_ld;
  logic       w_wr;

  assign w_op = r_ir[8:6];
  assign w_rx = r_ir[5:3];
  assign w_ry = r_ir[2:0];

  // Per-state decode: bus source, load strobes, done and next state.
  always_comb begin
    w_next   = r_state;
    w_sel    = SEL_IDLE;
    w_done   = 1'b0;
    w_ir_ld  = 1'b0;
    w_imm_ld = 1'b0;
    w_a_ld   = 1'b0;
    w_g_ld   = 1'b0;
    w_wr     = 1'b0;
    case (r_state)
      T0: begin
        if (bif.run) begin
          w_ir_ld = 1'b1;
          w_next  = T1;
        end
      end
      T1: begin
        case (w_op)
          OP_MV: begin
            w_sel  = {1'b0, w_ry};
            w_wr   = 1'b1;
            w_done = 1'b1;
            w_next = T0;
          end
          OP_MVI: begin
            w_imm_ld = 1'b1;
            w_next   = T2;
          end
          OP_ADD, OP_SUB: begin
            w_sel  = {1'b0, w_rx};
            w_a_ld = 1'b1;
            w_next = T2;
          end
          default: begin
            w_done = 1'b1;
            w_next = T0;
          end
        endcase
      end
      T2: begin
        case (w_op)
          OP_MVI: begin
            w_sel  = SEL_IMM;
            w_wr   = 1'b1;
            w_done = 1'b1;
            w_next = T0;
          end
          OP_ADD, OP_SUB: begin
            w_sel  = {1'b0, w_ry};
            w_g_ld = 1'b1;
            w_next = T3;
          end
          default: w_next = T0;
        endcase
      end
      default: begin
        if (w_op == OP_ADD || w_op == OP_SUB) begin
          w_sel  = SEL_G;
          w_wr   = 1'b1;
          w_done = 1'b1;
        end
        w_next = T0;
      end
    endcase
  end

  // State and datapath registers; every register write takes the bus value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= T0;
      r_ir    <= '0;
      r_a     <= '0;
      r_g     <= '0;
      r_imm   <= '0;
      for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      if (w_ir_ld)  r_ir  <= bif.din[WIDTH-1:WIDTH-9];
      if (w_imm_ld) r_imm <= bif.din;
      if (w_a_ld)   r_a   <= bif.bus;
      if (w_g_ld)   r_g   <= (w_op == OP_SUB) ? (r_a - bif.bus) : (r_a + bif.bus);
      if (w_wr)     r_regs[w_rx] <= bif.bus;
    end
  end

  assign bif.sel  = w_sel;
  assign bif.done = w_done;
  assign bif.imm  = r_imm;
  assign bif.r    = r_g;
  assign bif.r0   = r_regs[0];
  assign bif.r1   = r_regs[1];
  assign bif.r2   = r_regs[2];
  assign bif.r3   = r_regs[3];
  assign bif.r4   = r_regs[4];
  assign bif.r5   = r_regs[5];
  assign bif.r6   = r_regs[6];
  assign bif.r7   = r_regs[7];

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer; the bench models the bus multiplexer.
module tb_bus_sequencer;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  bus_sequencer_if #(.WIDTH(16)) bif ();

  bus_sequencer #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] w_regs [8];
  assign w_regs[0] = bif.r0;
  assign w_regs[1] = bif.r1;
  assign w_regs[2] = bif.r2;
  assign w_regs[3] = bif.r3;
  assign w_regs[4] = bif.r4;
  assign w_regs[5] = bif.r5;
  assign w_regs[6] = bif.r6;
  assign w_regs[7] = bif.r7;

  // Bus multiplexer: 0xxx -> Rxxx, 1000 -> imm, 1001 -> G, otherwise 0.
  always_comb begin
    if (bif.sel[3] == 1'b0)   bif.bus = w_regs[bif.sel[2:0]];
    else if (bif.sel == 4'h8) bif.bus = bif.imm;
    else if (bif.sel == 4'h9) bif.bus = bif.r;
    else                      bif.bus = 16'h0000;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loads a register through a mvi instruction (setup only).
  task automatic load_reg(input logic [2:0] rx, input logic [15:0] val);
    bif.run = 1'b1;
    bif.din = {3'b001, rx, 10'b0};
    step();
    bif.run = 1'b0;
    bif.din = val;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.run = 1'b0;
    bif.din = 16'h0000;
    step();
    step();
    rst = 1'b0;
    vectors++;
    if (bif.sel !== 4'hF) begin miscompares++; $display("FAIL reset_sel: got %h expected f", bif.sel); end
    vectors++;
    if (bif.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bif.done); end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (w_regs[i] !== 16'h0000) begin miscompares++; $display("FAIL reset_r%0d: got %h expected 0000", i, w_regs[i]); end
    end
    vectors++;
    if (bif.imm !== 16'h0000 || bif.r !== 16'h0000) begin
      miscompares++; $display("FAIL reset_imm_g: got imm=%h g=%h expected 0000/0000", bif.imm, bif.r);
    end
  endtask

  task automatic test_mvi();
    bif.run = 1'b1;
    bif.din = 16'h2000;
    step();
    bif.run = 1'b0;
    bif.din = 16'h1234;
    vectors++;
    if (bif.sel !== 4'hF || bif.done !== 1'b0) begin
      miscompares++; $display("FAIL mvi_t1: got sel=%h done=%b expected f/0", bif.sel, bif.done);
    end
    step();
    bif.din = 16'hDEAD;
    vectors++;
    if (bif.sel !== 4'h8 || bif.done !== 1'b1) begin
      miscompares++; $display("FAIL mvi_t2: got sel=%h done=%b expected 8/1", bif.sel, bif.done);
    end
    step();
    vectors++;
    if (bif.r0 !== 16'h1234 || bif.imm !== 16'h1234) begin
      miscompares++; $display("FAIL mvi_result: got r0=%h imm=%h expected 1234/1234", bif.r0, bif.imm);
    end
    vectors++;
    if (bif.done !== 1'b0) begin miscompares++; $display("FAIL mvi_done_after: got %b expected 0", bif.done); end
  endtask

  task automatic test_mv();
    bif.run = 1'b1;
    bif.din = 16'h0400;
    step();
    bif.run = 1'b0;
    vectors++;
    if (bif.sel !== 4'h0 || bif.done !== 1'b1) begin
      miscompares++; $display("FAIL mv_t1: got sel=%h done=%b expected 0/1", bif.sel, bif.done);
    end
    step();
    vectors++;
    if (bif.r1 !== 16'h1234 || bif.r0 !== 16'h1234) begin
      miscompares++; $display("FAIL mv_result: got r1=%h r0=%h expected 1234/1234", bif.r1, bif.r0);
    end
  endtask

  task automatic test_add_wrap();
    load_reg(3'd2, 16'hFFFF);
    load_reg(3'd3, 16'h0002);
    bif.run = 1'b1;
    bif.din = 16'h4980;
    step();
    bif.run = 1'b0;
    vectors++;
    if (bif.sel !== 4'h2 || bif.done !== 1'b0) begin
      miscompares++; $display("FAIL add_t1: got sel=%h done=%b expected 2/0", bif.sel, bif.done);
    end
    step();
    vectors++;
    if (bif.sel !== 4'h3 || bif.done !== 1'b0) begin
      miscompares++; $display("FAIL add_t2: got sel=%h done=%b expected 3/0", bif.sel, bif.done);
    end
    step();
    vectors++;
    if (bif.sel !== 4'h9 || bif.done !== 1'b1 || bif.r !== 16'h0001) begin
      miscompares++; $display("FAIL add_t3: got sel=%h done=%b g=%h expected 9/1/0001", bif.sel, bif.done, bif.r);
    end
    step();
    vectors++;
    if (bif.r2 !== 16'h0001 || bif.r3 !== 16'h0002) begin
      miscompares++; $display("FAIL add_result: got r2=%h r3=%h expected 0001/0002", bif.r2, bif.r3);
    end
  endtask

  task automatic test_sub_underflow();
    load_reg(3'd4, 16'h0003);
    load_reg(3'd5, 16'h0005);
    bif.run = 1'b1;
    bif.din = 16'h7280;
    step();
    bif.run = 1'b0;
    step();
    step();
    step();
    vectors++;
    if (bif.r4 !== 16'hFFFE || bif.r !== 16'hFFFE) begin
      miscompares++; $display("FAIL sub_result: got r4=%h g=%h expected fffe/fffe", bif.r4, bif.r);
    end
  endtask

  task automatic test_back_to_back();
    // mv R6,R4 ; nop ; add R1,R1 with run held high, dropped inside the add.
    bif.run = 1'b1;
    bif.din = 16'h1A00;
    step();
    vectors++;
    if (bif.sel !== 4'h4 || bif.done !== 1'b1) begin
      miscompares++; $display("FAIL b2b_mv: got sel=%h done=%b expected 4/1", bif.sel, bif.done);
    end
    bif.din = 16'hE000;
    step();
    vectors++;
    if (bif.sel !== 4'hF || bif.done !== 1'b0) begin
      miscompares++; $display("FAIL b2b_t0a: got sel=%h done=%b expected f/0", bif.sel, bif.done);
    end
    step();
    vectors++;
    if (bif.sel !== 4'hF || bif.done !== 1'b1) begin
      miscompares++; $display("FAIL b2b_nop: got sel=%h done=%b expected f/1", bif.sel, bif.done);
    end
    bif.din = 16'h4480;
    step();
    step();
    vectors++;
    if (bif.sel !== 4'h1 || bif.done !== 1'b0) begin
      miscompares++; $display("FAIL b2b_add_t1: got sel=%h done=%b expected 1/0", bif.sel, bif.done);
    end
    bif.run = 1'b0;
    bif.din = 16'hFFFF;
    step();
    step();
    vectors++;
    if (bif.done !== 1'b1 || bif.r !== 16'h2468) begin
      miscompares++; $display("FAIL b2b_add_t3: got done=%b g=%h expected 1/2468", bif.done, bif.r);
    end
    step();
    vectors++;
    if (bif.r1 !== 16'h2468 || bif.r6 !== 16'hFFFE) begin
      miscompares++; $display("FAIL b2b_result: got r1=%h r6=%h expected 2468/fffe", bif.r1, bif.r6);
    end
    step();
    vectors++;
    if (bif.done !== 1'b0 || bif.sel !== 4'hF) begin
      miscompares++; $display("FAIL b2b_no_fetch: got sel=%h done=%b expected f/0", bif.sel, bif.done);
    end
    step();
    vectors++;
    if (bif.done !== 1'b0 || bif.r1 !== 16'h2468) begin
      miscompares++; $display("FAIL b2b_idle: got done=%b r1=%h expected 0/2468", bif.done, bif.r1);
    end
  endtask

  task automatic test_reset_mid_add();
    load_reg(3'd7, 16'h0055);
    bif.run = 1'b1;
    bif.din = 16'h5F80;
    step();
    bif.run = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (bif.sel !== 4'hF || bif.done !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_state: got sel=%h done=%b expected f/0", bif.sel, bif.done);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (w_regs[i] !== 16'h0000) begin miscompares++; $display("FAIL rstmid_r%0d: got %h expected 0000", i, w_regs[i]); end
    end
    step();
    step();
    vectors++;
    if (bif.r7 !== 16'h0000 || bif.r !== 16'h0000 || bif.done !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_nowrite: got r7=%h g=%h done=%b expected 0000/0000/0", bif.r7, bif.r, bif.done);
    end
    bif.run = 1'b1;
    bif.din = 16'hE000;
    step();
    bif.run = 1'b0;
    vectors++;
    if (bif.done !== 1'b1 || bif.sel !== 4'hF) begin
      miscompares++; $display("FAIL nop_t1: got sel=%h done=%b expected f/1", bif.sel, bif.done);
    end
    step();
    vectors++;
    if (bif.r7 !== 16'h0000 || bif.r0 !== 16'h0000 || bif.imm !== 16'h0000 || bif.done !== 1'b0) begin
      miscompares++; $display("FAIL nop_result: got r7=%h r0=%h imm=%h done=%b expected 0/0/0/0", bif.r7, bif.r0, bif.imm, bif.done);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bif.run     = 1'b0;
    bif.din     = 16'h0000;
    test_reset();
    test_mvi();
    test_mv();
    test_add_wrap();
    test_sub_underflow();
    test_back_to_back();
    test_reset_mid_add();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
